// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_expand
//  Purpose  : Iterative AES-128 key schedule. Loads one 128-bit cipher key and
//             computes round keys 0..NUM_ROUNDS, one per enabled clock, into an
//             internal bank. The encrypt datapath reads any entry by index
//             through a registered read port (1-cycle latency).
//  Ports    : clk_i     clock, rising edge
//             rst_ni    asynchronous reset, active low
//             en_i      clock enable; when low every register holds
//             start_i   request expansion of key_i (accepted in IDLE/DONE)
//             key_i     cipher key, key_i[127:96] = w0
//             rk_idx_i  round-key read index
//             busy_o    expansion in progress
//             ready_o   bank holds the complete schedule of the last key
//             rk_o      registered bank[rk_idx_i], zero for out-of-range index
//  Revision : 1.0  initial release
// ============================================================================
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [127:0]     key_i,
  input  logic [IDX_W-1:0] rk_idx_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [127:0]     rk_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset 8*(255-a); for an 8-bit a, 255-a is ~a.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return c_SBOX[{~a, 3'b000} +: 8];
  endfunction

  state_e           state_q;
  logic [IDX_W-1:0] ctr_q;
  logic [7:0]       rcon_q;
  logic             busy_q;
  logic             ready_q;
  logic [127:0]     rk_q;
  logic [127:0]     bank_q [0:NUM_ROUNDS];

  logic [127:0]     w_prev;
  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [31:0]      w_t;
  logic [127:0]     key_d;
  logic [7:0]       rcon_d;

  // Previous round key; only meaningful in EXPAND where ctr_q >= 1.
  assign w_prev = bank_q[ctr_q - c_ONE];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
  end

  always_comb begin
    key_d           = '0;
    w_t             = w_sub ^ {rcon_q, 24'h000000};
    key_d[127:96]   = w_prev[127:96] ^ w_t;
    key_d[95:64]    = w_prev[95:64]  ^ key_d[127:96];
    key_d[63:32]    = w_prev[63:32]  ^ key_d[95:64];
    key_d[31:0]     = w_prev[31:0]   ^ key_d[63:32];
    rcon_d          = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      rk_q    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (en_i) begin
      rk_q <= (rk_idx_i <= c_LAST) ? bank_q[rk_idx_i] : '0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            bank_q[0] <= key_i;
            ctr_q     <= c_ONE;
            rcon_q    <= 8'h01;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          // start_i is deliberately ignored here: the running schedule finishes.
          bank_q[ctr_q] <= key_d;
          rcon_q        <= rcon_d;
          ctr_q         <= ctr_q + c_ONE;
          if (ctr_q == c_LAST) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign rk_o    = rk_q;

endmodule
`default_nettype wire
